// File: rtl/ex_div_pkg.sv
// Shared constants, FSM encoding and latched-operation payload for the EX-stage divider.
package ex_div_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [6:0] OPCODE_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OPCODE_R_W_TYPE = 7'b0111011;
  localparam logic [6:0] FUNCT7_MULDIV   = 7'b0000001;

  localparam logic [2:0] FUNCT3_DIV  = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU = 3'b101;
  localparam logic [2:0] FUNCT3_REM  = 3'b110;
  localparam logic [2:0] FUNCT3_REMU = 3'b111;

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'b00,
    DIV_STATE_BUSY = 2'b01,
    DIV_STATE_DONE = 2'b10
  } div_state_e;

  // Attributes of the accepted op that shape the final result.
  typedef struct packed {
    logic is_rem;
    logic is_w;
    logic neg_q;
    logic neg_r;
  } div_op_t;

  // Sign-extend a word-sized value to the full datapath width.
  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] x);
    return {{(XLEN-WLEN){x[WLEN-1]}}, x};
  endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring radix-2 unsigned divider: one quotient bit per step, XLEN or WLEN steps.
module div_core_unsigned
  import ex_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_step,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_last_c,
  output logic [XLEN-1:0] o_quo_nxt_c,
  output logic [XLEN-1:0] o_rem_nxt_c
);

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic [XLEN:0]    w_shift;
  logic [XLEN-1:0]  w_trial;
  logic             w_ge;

  // One restoring step: shift the next dividend bit in and try to subtract.
  always_comb begin
    w_shift     = {r_rem, r_quo[XLEN-1]};
    w_ge        = (w_shift >= {1'b0, r_dvs});
    w_trial     = w_shift[XLEN-1:0] - r_dvs;
    o_rem_nxt_c = w_ge ? w_trial : w_shift[XLEN-1:0];
    o_quo_nxt_c = {r_quo[XLEN-2:0], w_ge};
    o_last_c    = (r_cnt == '0);
  end

  // Operand load on start, then iterate; W ops pre-shift the dividend to the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_quo <= i_w ? {i_dividend[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= i_w ? CNT_W'(WLEN-1) : CNT_W'(XLEN-1);
    end else if (i_step) begin
      r_quo <= o_quo_nxt_c;
      r_rem <= o_rem_nxt_c;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_div.sv
// EX-stage RV64M divide/remainder unit: sign handling, special cases, W extension, stall FSM.
module ex_div
  import ex_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  div_op_t         r_op;
  div_op_t         w_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_result;

  logic            w_is_w;
  logic            w_is_div;
  logic            w_signed;
  logic            w_rem;
  logic [XLEN-1:0] w_a_ext;
  logic [XLEN-1:0] w_b_ext;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_raw;
  logic [XLEN-1:0] w_spec_res;
  logic            w_start;
  logic            w_last;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_q_signed;
  logic [XLEN-1:0] w_r_signed;
  logic [XLEN-1:0] w_raw;
  logic [XLEN-1:0] w_fin;

  // Decode, operand extension/magnitudes and special-case results from ID/EX.
  always_comb begin
    w_is_w   = (opcode_i == OPCODE_R_W_TYPE);
    w_is_div = (funct7_i == FUNCT7_MULDIV) &&
               ((opcode_i == OPCODE_R_TYPE) || w_is_w) &&
               ((funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_DIVU) ||
                (funct3_i == FUNCT3_REM) || (funct3_i == FUNCT3_REMU));
    w_signed = (funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM);
    w_rem    = (funct3_i == FUNCT3_REM) || (funct3_i == FUNCT3_REMU);

    if (w_is_w) begin
      w_a_ext = w_signed ? sext_w(rs1_data_i[WLEN-1:0]) : XLEN'(rs1_data_i[WLEN-1:0]);
      w_b_ext = w_signed ? sext_w(rs2_data_i[WLEN-1:0]) : XLEN'(rs2_data_i[WLEN-1:0]);
    end else begin
      w_a_ext = rs1_data_i;
      w_b_ext = rs2_data_i;
    end

    w_a_neg = w_signed & w_a_ext[XLEN-1];
    w_b_neg = w_signed & w_b_ext[XLEN-1];
    w_a_mag = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag = w_b_neg ? -w_b_ext : w_b_ext;

    w_div0    = (w_b_ext == '0);
    w_ovf     = w_signed && (w_a_ext == (w_is_w ? MIN_W : MIN_X)) && (w_b_ext == {XLEN{1'b1}});
    w_special = w_div0 | w_ovf;

    if (w_div0) begin
      w_spec_raw = w_rem ? w_a_ext : {XLEN{1'b1}};
    end else begin
      w_spec_raw = w_rem ? {XLEN{1'b0}} : w_a_ext;
    end
    w_spec_res = w_is_w ? sext_w(w_spec_raw[WLEN-1:0]) : w_spec_raw;

    w_op.is_rem = w_rem;
    w_op.is_w   = w_is_w;
    w_op.neg_q  = w_a_neg ^ w_b_neg;
    w_op.neg_r  = w_a_neg;

    w_start = rst && (r_state == DIV_STATE_IDLE) && w_is_div && !flush_i;
  end

  div_core_unsigned u_core (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_step      (r_state == DIV_STATE_BUSY),
    .i_w         (w_is_w),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_last_c    (w_last),
    .o_quo_nxt_c (w_quo_nxt),
    .o_rem_nxt_c (w_rem_nxt)
  );

  // Final sign fix-up and W sign-extension applied to the last iteration's values.
  always_comb begin
    w_q_signed = r_op.neg_q ? -w_quo_nxt : w_quo_nxt;
    w_r_signed = r_op.neg_r ? -w_rem_nxt : w_rem_nxt;
    w_raw      = r_op.is_rem ? w_r_signed : w_q_signed;
    w_fin      = r_op.is_w ? sext_w(w_raw[WLEN-1:0]) : w_raw;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DIV_STATE_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and stall request; stall drops in the same cycle as a flush.
  always_comb begin
    w_state_nxt = r_state;
    stall_req_o = 1'b0;
    case (r_state)
      DIV_STATE_IDLE: begin
        if (w_start) begin
          stall_req_o = 1'b1;
          w_state_nxt = w_special ? DIV_STATE_DONE : DIV_STATE_BUSY;
        end
      end
      DIV_STATE_BUSY: begin
        if (flush_i) begin
          w_state_nxt = DIV_STATE_IDLE;
        end else begin
          stall_req_o = 1'b1;
          if (w_last) begin
            w_state_nxt = DIV_STATE_DONE;
          end
        end
      end
      DIV_STATE_DONE: begin
        w_state_nxt = DIV_STATE_IDLE;
      end
      default: begin
        w_state_nxt = DIV_STATE_IDLE;
      end
    endcase
  end

  // Op attributes, destination and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= '0;
      r_rd     <= '0;
      r_result <= '0;
    end else begin
      if (w_start) begin
        r_op <= w_op;
        r_rd <= rd_addr_i;
        if (w_special) begin
          r_result <= w_spec_res;
        end
      end
      if ((r_state == DIV_STATE_BUSY) && !flush_i && w_last) begin
        r_result <= w_fin;
      end
    end
  end

  assign done_o    = (r_state == DIV_STATE_DONE);
  assign result_o  = r_result;
  assign rd_addr_o = r_rd;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div against an arithmetic reference model.
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_div dut (
    .clk         (clk),
    .rst         (rst),
    .opcode_i    (opcode),
    .funct3_i    (funct3),
    .funct7_i    (funct7),
    .rs1_data_i  (rs1),
    .rs2_data_i  (rs2),
    .rd_addr_i   (rd_addr),
    .flush_i     (flush),
    .stall_req_o (stall_req),
    .done_o      (done),
    .result_o    (result),
    .rd_addr_o   (rd_out)
  );

  typedef struct {
    logic [2:0]  f3;
    bit          w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } case_t;

  // Reference: RISC-V M-extension semantics from plain signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f3, input bit w,
                                        input logic [63:0] a, input logic [63:0] b);
    bit          sg = !f3[0];
    bit          rm = f3[1];
    longint      sa;
    longint      sb;
    int          a32;
    int          b32;
    logic [31:0] r32;
    if (!w) begin
      if (b == 64'd0) return rm ? a : {64{1'b1}};
      if (sg) begin
        if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return rm ? 64'd0 : a;
        sa = a;
        sb = b;
        return rm ? 64'(sa % sb) : 64'(sa / sb);
      end
      return rm ? a % b : a / b;
    end
    a32 = a[31:0];
    b32 = b[31:0];
    if (b[31:0] == 32'd0) r32 = rm ? a[31:0] : 32'hFFFF_FFFF;
    else if (sg) begin
      if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) r32 = rm ? 32'd0 : a[31:0];
      else r32 = rm ? 32'(a32 % b32) : 32'(a32 / b32);
    end else r32 = rm ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input bit w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit sg = !f3[0];
    if (!w) begin
      if (b == 64'd0) return 1;
      if (sg && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 1;
      return 65;
    end
    if (b[31:0] == 32'd0) return 1;
    if (sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'($urandom_range(1, 40));
      2:       return -64'($urandom_range(1, 40));
      3:       return 64'h8000_0000_0000_0000;
      4:       return {64{1'b1}};
      5:       return {32'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 15))};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic drive_op(input logic [2:0] f3, input bit w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd);
    opcode  = w ? 7'b0111011 : 7'b0110011;
    funct7  = 7'b0000001;
    funct3  = f3;
    rs1     = a;
    rs2     = b;
    rd_addr = rd;
  endtask

  task automatic drive_nop();
    opcode  = 7'b0010011;
    funct7  = 7'd0;
    funct3  = 3'd0;
    rs1     = 64'd0;
    rs2     = 64'd0;
    rd_addr = 5'd0;
  endtask

  task automatic idle(input int n);
    drive_nop();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents an op (after any DONE cycle in progress) and waits for done with a cycle bound.
  task automatic run_op(input logic [2:0] f3, input bit w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd,
                        output int lat, output int stalls, output logic [63:0] res,
                        output logic [4:0] rdo, output logic t0_done);
    drive_op(f3, w, a, b, rd);
    if (done === 1'b1) begin
      @(posedge clk);
      #1;
    end
    #1;
    t0_done = done;
    lat     = -1;
    stalls  = 0;
    res     = 'x;
    rdo     = 'x;
    for (int c = 1; c <= 200; c++) begin
      if (stall_req === 1'b1) stalls++;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = c;
        res = result;
        rdo = rd_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    flush = 1'b0;
    drive_nop();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall_req); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd: got %h expected 0", rd_out); end
    drive_op(3'b100, 1'b0, 64'd7, 64'd2, 5'd1);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall_with_div: got %b expected 0", stall_req); end
    drive_nop();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    case_t cs [14] = '{
      '{3'b100, 1'b0, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA},
      '{3'b110, 1'b0, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE},
      '{3'b111, 1'b0, 64'd20, 64'd3, 64'd2},
      '{3'b101, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
      '{3'b110, 1'b0, 64'h1234, 64'd0, 64'h1234},
      '{3'b100, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000},
      '{3'b110, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'd0},
      '{3'b100, 1'b1, 64'h8000_0000, {64{1'b1}}, 64'hFFFF_FFFF_8000_0000},
      '{3'b101, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF},
      '{3'b111, 1'b1, 64'h1_8000_0005, 64'h10, 64'd5},
      '{3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF},
      '{3'b110, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF},
      '{3'b100, 1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF},
      '{3'b111, 1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000}
    };
    int          lat;
    int          stalls;
    int          el;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic [4:0]  rd;
    logic        t0d;
    for (int i = 0; i < 14; i++) begin
      rd = 5'($urandom_range(1, 31));
      el = exp_lat(cs[i].f3, cs[i].w, cs[i].a, cs[i].b);
      run_op(cs[i].f3, cs[i].w, cs[i].a, cs[i].b, rd, lat, stalls, res, rdo, t0d);
      checks++; if (res !== cs[i].exp) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, cs[i].exp); end
      checks++; if (lat !== el) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, el); end
      checks++; if (stalls !== el) begin errors++; $display("FAIL dir%0d_stall_cycles: got %0d expected %0d", i, stalls, el); end
      checks++; if (rdo !== rd) begin errors++; $display("FAIL dir%0d_rd: got %0d expected %0d", i, rdo, rd); end
      idle(1);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width: got %b expected 0", i, done); end
      idle(1);
    end
  endtask

  task automatic test_not_div();
    logic seen = 1'b0;
    drive_op(3'b000, 1'b0, 64'd9, 64'd3, 5'd4);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mul_stall: got %b expected 0", stall_req); end
    funct3 = 3'b100;
    funct7 = 7'd0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL xor_stall: got %b expected 0", stall_req); end
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL not_div_done: got %b expected 0", seen); end
    idle(1);
  endtask

  task automatic test_flush_busy();
    logic seen = 1'b0;
    drive_op(3'b101, 1'b0, 64'd1000, 64'd7, 5'd9);
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush_t0_stall: got %b expected 1", stall_req); end
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall_drop: got %b expected 0", stall_req); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive_nop();
    for (int c = 0; c < 80; c++) begin
      if (done === 1'b1 || stall_req === 1'b1) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b expected 0", seen); end
  endtask

  task automatic test_flush_idle();
    logic seen = 1'b0;
    flush = 1'b1;
    drive_op(3'b100, 1'b0, 64'd50, 64'd0, 5'd3);
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %b expected 0", stall_req); end
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_done: got %b expected 0", seen); end
    drive_nop();
    flush = 1'b0;
    idle(1);
  endtask

  task automatic test_flush_done();
    int          lat;
    int          stalls;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic        t0d;
    run_op(3'b100, 1'b0, 64'd100, 64'd9, 5'd12, lat, stalls, res, rdo, t0d);
    flush = 1'b1;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_done_pulse: got %b expected 1", done); end
    checks++; if (result !== 64'd11) begin errors++; $display("FAIL flush_done_result: got %h expected %h", result, 64'd11); end
    drive_nop();
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done_after: got %b expected 0", done); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic        seen = 1'b0;
    int          lat;
    int          stalls;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic        t0d;
    drive_op(3'b100, 1'b0, 64'd100, 64'd7, 5'd5);
    #1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", stall_req); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (result !== 64'd0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL rstmid_rd: got %h expected 0", rd_out); end
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 5'd6, lat, stalls, res, rdo, t0d);
    checks++; if (lat !== 65) begin errors++; $display("FAIL rstmid_restart_latency: got %0d expected 65", lat); end
    checks++; if (res !== 64'd14) begin errors++; $display("FAIL rstmid_restart_result: got %h expected %h", res, 64'd14); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    case_t cs [3] = '{
      '{3'b100, 1'b0, 64'd1000, -64'd10, -64'd100},
      '{3'b111, 1'b1, 64'd77, 64'd10, 64'd7},
      '{3'b101, 1'b0, 64'd9, 64'd0, {64{1'b1}}}
    };
    int          lat;
    int          stalls;
    int          el;
    logic [63:0] res;
    logic [4:0]  rdo;
    logic        t0d;
    for (int i = 0; i < 3; i++) begin
      el = exp_lat(cs[i].f3, cs[i].w, cs[i].a, cs[i].b);
      run_op(cs[i].f3, cs[i].w, cs[i].a, cs[i].b, 5'(20 + i), lat, stalls, res, rdo, t0d);
      checks++; if (res !== cs[i].exp) begin errors++; $display("FAIL b2b%0d_result: got %h expected %h", i, res, cs[i].exp); end
      checks++; if (lat !== el) begin errors++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, el); end
      checks++; if (rdo !== 5'(20 + i)) begin errors++; $display("FAIL b2b%0d_rd: got %0d expected %0d", i, rdo, 20 + i); end
      if (i > 0) begin
        checks++; if (t0d !== 1'b0) begin errors++; $display("FAIL b2b%0d_done_repeat: got %b expected 0", i, t0d); end
      end
    end
    idle(2);
  endtask

  task automatic test_random();
    int          lat;
    int          stalls;
    int          el;
    logic [63:0] res;
    logic [63:0] ex;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rdo;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit          w;
    logic        t0d;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = rand_opnd();
      b  = rand_opnd();
      rd = 5'($urandom);
      ex = model(f3, w, a, b);
      el = exp_lat(f3, w, a, b);
      run_op(f3, w, a, b, rd, lat, stalls, res, rdo, t0d);
      checks++; if (res !== ex) begin errors++; $display("FAIL rnd%0d_result f3=%b w=%0d a=%h b=%h: got %h expected %h", i, f3, w, a, b, res, ex); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, el); end
      checks++; if (rdo !== rd) begin errors++; $display("FAIL rnd%0d_rd: got %0d expected %0d", i, rdo, rd); end
      if ($urandom_range(0, 1) == 0) idle(1);
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_not_div();
    test_flush_busy();
    test_flush_idle();
    test_flush_done();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
Name: ex_div

Overview:
- Multi-cycle RV64M integer divide/remainder unit in the EX stage.
- Consumes the decoded instruction fields and operand data registered by the ID/EX pipeline register.
- Holds the pipeline via a stall request while it iterates, then presents a one-cycle result to the EX result mux and the EX/MEM register.
- Covers DIV, DIVU, REM, REMU and the W variants DIVW, DIVUW, REMW, REMUW.

Parameters:
- XLEN, 64, datapath width.
- WLEN, 32, operand width for W-variant ops.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- opcode_i  in  7  opcode from ID/EX.
- funct3_i  in  3  funct3 from ID/EX.
- funct7_i  in  7  funct7 from ID/EX.
- rs1_data_i  in  XLEN  dividend.
- rs2_data_i  in  XLEN  divisor.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  pipeline flush (branch redirect); aborts any operation in progress.
- stall_req_o  out  1  request to the pipeline controller to drive CTRL_STATE_Block on IF/ID and ID/EX.
- done_o  out  1  one-cycle pulse; result_o and rd_addr_o are valid.
- result_o  out  XLEN  quotient or remainder.
- rd_addr_o  out  5  destination register of the completed op.

Behaviour:
- Reset (rst=0, async) forces: state=IDLE, stall_req_o=0, done_o=0, result_o=0, rd_addr_o=0, all internal registers 0.
- is_div is true when funct7_i=0000001, funct3_i[2]=1, and opcode_i is 0110011 (XLEN op) or 0111011 (W op).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - is_div and !flush_i: latch operands, op type, W flag and rd_addr_i.
  - stall_req_o is asserted combinationally in this same cycle.
  - Next state is BUSY, or DONE if a special case applies.
- BUSY:
  - Restoring radix-2 unsigned iteration, one quotient bit per cycle.
  - Iteration counter runs XLEN-1..0 (WLEN-1..0 for W ops).
  - stall_req_o=1 throughout.
  - Counter reaching 0 sets next state to DONE.
- DONE:
  - done_o=1 and result_o valid; stall_req_o=0, so ID/EX advances at the end of this cycle.
  - Inputs are ignored in DONE, so the still-present div instruction is not restarted.
  - Next state is always IDLE.
- Latency: start cycle T0; done_o at T0+XLEN+1 (65) for 64-bit ops, T0+WLEN+1 (33) for W ops. Special cases complete with done_o at T0+1.
- Signed ops:
  - Operate on operand magnitudes.
  - Quotient sign = sign(dividend) XOR sign(divisor).
  - Remainder sign = sign(dividend).
- W ops:
  - Operands are bits [31:0]; the sign is bit 31 for signed variants, and upper bits are ignored.
  - The 32-bit result is sign-extended from bit 31 to XLEN. This applies to DIVUW/REMUW as well, per ISA.
- Special cases (widths per op):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0.
- flush_i=1 in BUSY: state goes to IDLE next cycle, no done_o, stall_req_o drops that same cycle.
- flush_i=1 in IDLE: no start.
- flush_i in DONE: done_o still asserts and the EX/MEM bubble logic discards it.
- Reset asserted mid-operation aborts immediately; no done_o after release.
- done_o is never asserted for two consecutive cycles.
- Back-to-back divides: the second starts on the cycle after DONE, when ID/EX presents it.

Decomposition:
- Shared defines.v additions:
  - Opcode_R_type (0110011) and Opcode_R_W_type (0111011).
  - funct7_muldiv (0000001).
  - funct3_div/divu/rem/remu (100/101/110/111).
  - DIV_STATE_IDLE/BUSY/DONE 2-bit encodings.
- One sub-module, div_core_unsigned:
  - Holds the iterative unsigned quotient/remainder registers and counter.
  - Has start/width-select inputs and a last-iteration flag.
- ex_div wraps it with sign handling, special cases, W extension and the FSM.

Test Plan:
- DIV 64-bit, rs1=-20, rs2=3 -> stall_req_o high 65 cycles; done_o at T0+65; result=0xFFFF_FFFF_FFFF_FFFA (-6).
- REM rs1=-20, rs2=3 -> result=-2. REMU rs1=20, rs2=3 -> result=2.
- DIVU rs2=0, rs1=0x1234 -> done_o at T0+1, result=0xFFFF_FFFF_FFFF_FFFF. REM same operands -> result=0x1234.
- DIV rs1=0x8000_0000_0000_0000, rs2=-1 -> result=0x8000_0000_0000_0000; REM -> 0. DIVW rs1=0x8000_0000, rs2=-1 -> 0xFFFF_FFFF_8000_0000.
- DIVUW rs1=0xFFFF_FFFF_FFFF_FFFE, rs2=2 -> done_o at T0+33; result=0x0000_0000_7FFF_FFFF.
- DIVU started, flush_i pulsed at T0+10 -> stall_req_o=0 from T0+10, no done_o. Then rst low at T0+20 of a new op -> all outputs 0, FSM IDLE.
